// File: rtl/change_dispenser.sv
// change_dispenser: queues change requests in a small FIFO and pays each one
// out as a greedy series of notes (100/50/20/10/5) over a valid/ready
// handshake, followed by at most one coin pulse for any residue below 5.
// Optional build macro: CHANGE_STATS_EN adds notes_total, value_total and
// coins_total counters as extra outputs.
module change_dispenser #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          chg_valid,
  input  logic [AW-1:0] chg_amount,
  output logic          note_valid,
  output logic [6:0]    note_denom,
  input  logic          note_ready,
  output logic          coin_valid,
  output logic [2:0]    coin_amt,
  output logic          done,
  output logic          busy,
  output logic          fifo_full,
  output logic          overflow
`ifdef CHANGE_STATS_EN
  ,
  output logic [31:0]   notes_total,
  output logic [31:0]   value_total,
  output logic [15:0]   coins_total
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_ISSUE,
    S_COIN,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] rem_q, rem_d;
  logic [PW:0]   wr_ptr_q, wr_ptr_d;
  logic [PW:0]   rd_ptr_q, rd_ptr_d;
  logic          note_valid_q, note_valid_d;
  logic [6:0]    note_denom_q, note_denom_d;
  logic          coin_valid_q, coin_valid_d;
  logic [2:0]    coin_amt_q, coin_amt_d;
  logic          done_q, done_d;
  logic          overflow_q, overflow_d;
  logic [AW-1:0] mem_q [DEPTH];

  logic          fifo_empty;
  logic          full;
  logic          req_nz;
  logic          push;
  logic          pop;
  logic [6:0]    best_denom;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign req_nz     = chg_valid && (chg_amount != '0);
  // A full FIFO refuses the push even if the FSM pops in the same cycle.
  assign push       = req_nz && !full;

  // Largest denomination not exceeding the remaining amount (needs rem >= 5).
  always_comb begin
    best_denom = 7'd5;
    if (rem_q >= AW'(100))     best_denom = 7'd100;
    else if (rem_q >= AW'(50)) best_denom = 7'd50;
    else if (rem_q >= AW'(20)) best_denom = 7'd20;
    else if (rem_q >= AW'(10)) best_denom = 7'd10;
  end

  // Next-state logic for FSM, FIFO pointers and registered outputs.
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    note_valid_d = note_valid_q;
    note_denom_d = note_denom_q;
    coin_valid_d = 1'b0;
    coin_amt_d   = '0;
    done_d       = 1'b0;
    overflow_d   = overflow_q | (req_nz && full);
    pop          = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          rem_d   = mem_q[rd_ptr_q[PW-1:0]];
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (rem_q >= AW'(5)) begin
          note_denom_d = best_denom;
          note_valid_d = 1'b1;
          state_d      = S_ISSUE;
        end else if (rem_q != '0) begin
          coin_valid_d = 1'b1;
          coin_amt_d   = rem_q[2:0];
          rem_d        = '0;
          state_d      = S_COIN;
        end else begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_ISSUE: begin
        if (note_ready) begin
          rem_d        = rem_q - AW'(note_denom_q);
          note_valid_d = 1'b0;
          state_d      = S_CALC;
        end
      end
      S_COIN: begin
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, pop};
  end

  // FSM, FIFO pointer and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      rem_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      note_valid_q <= 1'b0;
      note_denom_q <= '0;
      coin_valid_q <= 1'b0;
      coin_amt_q   <= '0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      note_valid_q <= note_valid_d;
      note_denom_q <= note_denom_d;
      coin_valid_q <= coin_valid_d;
      coin_amt_q   <= coin_amt_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= chg_amount;
  end

  assign note_valid = note_valid_q;
  assign note_denom = note_denom_q;
  assign coin_valid = coin_valid_q;
  assign coin_amt   = coin_amt_q;
  assign done       = done_q;
  assign overflow   = overflow_q;
  assign fifo_full  = full;
  assign busy       = (state_q != S_IDLE) || !fifo_empty;

`ifdef CHANGE_STATS_EN
  logic [31:0] notes_total_q, notes_total_d;
  logic [31:0] value_total_q, value_total_d;
  logic [15:0] coins_total_q, coins_total_d;

  // Payout statistics; all counters wrap naturally.
  always_comb begin
    notes_total_d = notes_total_q;
    value_total_d = value_total_q;
    coins_total_d = coins_total_q;
    if (note_valid_q && note_ready) begin
      notes_total_d = notes_total_q + 32'd1;
      value_total_d = value_total_q + {25'd0, note_denom_q};
    end
    if (coin_valid_q) begin
      coins_total_d = coins_total_q + 16'd1;
      value_total_d = value_total_q + {29'd0, coin_amt_q};
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      notes_total_q <= '0;
      value_total_q <= '0;
      coins_total_q <= '0;
    end else begin
      notes_total_q <= notes_total_d;
      value_total_q <= value_total_d;
      coins_total_q <= coins_total_d;
    end
  end

  assign notes_total = notes_total_q;
  assign value_total = value_total_q;
  assign coins_total = coins_total_q;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed table of single requests, hand-written
// multi-cycle sequences (latency, stall, overflow, mid-payout reset) and a
// randomized phase scored against a greedy-payout reference model.
module tb_change_dispenser;

  localparam int DEPTH = 4;
  localparam int AW    = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          chg_valid = 1'b0;
  logic [AW-1:0] chg_amount = '0;
  logic          note_valid;
  logic [6:0]    note_denom;
  logic          note_ready = 1'b0;
  logic          coin_valid;
  logic [2:0]    coin_amt;
  logic          done;
  logic          busy;
  logic          fifo_full;
  logic          overflow;
`ifdef CHANGE_STATS_EN
  logic [31:0]   notes_total;
  logic [31:0]   value_total;
  logic [15:0]   coins_total;
`endif

  change_dispenser #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .chg_valid  (chg_valid),
    .chg_amount (chg_amount),
    .note_valid (note_valid),
    .note_denom (note_denom),
    .note_ready (note_ready),
    .coin_valid (coin_valid),
    .coin_amt   (coin_amt),
    .done       (done),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .overflow   (overflow)
`ifdef CHANGE_STATS_EN
    ,
    .notes_total(notes_total),
    .value_total(value_total),
    .coins_total(coins_total)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Observation counters filled by the monitor.
  int obs_notes, obs_sum, obs_coin, obs_coin_cnt, obs_done, obs_first, obs_order_bad;
  int prev_denom;
  bit sb_en = 1'b0;
  bit rand_ready = 1'b0;
  int exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_obs();
    obs_notes = 0; obs_sum = 0; obs_coin = 0; obs_coin_cnt = 0;
    obs_done = 0; obs_first = 0; obs_order_bad = 0; prev_denom = 127;
  endtask

  task automatic sb_event(input int ev);
    int e;
    if (!sb_en) return;
    if (exp_q.size() == 0) begin
      check("sb_unexpected_event", ev, -1);
    end else begin
      e = exp_q.pop_front();
      check("sb_event", ev, e);
    end
  endtask

  // Monitor: sample away from the active edge; a handshake seen here
  // completes at the following rising edge.
  always @(negedge clk) begin
    if (rstn) begin
      if (note_valid && note_ready) begin
        if (obs_notes == 0) obs_first = int'(note_denom);
        if (int'(note_denom) > prev_denom) obs_order_bad++;
        prev_denom = int'(note_denom);
        obs_notes++;
        obs_sum += int'(note_denom);
        sb_event(int'(note_denom));
      end
      if (coin_valid) begin
        obs_coin = int'(coin_amt);
        obs_coin_cnt++;
        sb_event(1000 + int'(coin_amt));
      end
      if (done) begin
        obs_done++;
        prev_denom = 127;
        sb_event(2000);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) note_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push(input int amt);
    chg_valid  = 1'b1;
    chg_amount = AW'(amt);
    step();
    chg_valid  = 1'b0;
    chg_amount = '0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (obs_done < target && n < budget) begin
      step();
      n++;
    end
  endtask

  // Reference: greedy payout expressed with division/modulo.
  task automatic model_request(input int amt);
    int r = amt;
    int denoms[5] = '{100, 50, 20, 10, 5};
    foreach (denoms[i]) begin
      int k = r / denoms[i];
      for (int j = 0; j < k; j++) exp_q.push_back(denoms[i]);
      r = r % denoms[i];
    end
    if (r != 0) exp_q.push_back(1000 + r);
    exp_q.push_back(2000);
  endtask

  typedef struct {
    int amt;
    int notes;
    int sum;
    int first;
    int coin;
    int dones;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int pushed;
    int rand_sum;
    int stall_bad;
    int n;

    tbl[0] = '{185,   5,   185, 100, 0, 1};
    tbl[1] = '{7,     1,     5,   5, 2, 1};
    tbl[2] = '{3,     0,     0,   0, 3, 1};
    tbl[3] = '{0,     0,     0,   0, 0, 0};
    tbl[4] = '{60,    2,    60,  50, 0, 1};
    tbl[5] = '{4,     0,     0,   0, 4, 1};
    tbl[6] = '{5,     1,     5,   5, 0, 1};
    tbl[7] = '{199,   5,   195, 100, 4, 1};
    tbl[8] = '{1,     0,     0,   0, 1, 1};
    tbl[9] = '{65535, 658, 65535, 100, 0, 1};

    clear_obs();
    // Reset state
    #2;
    check("rst_note_valid", int'(note_valid), 0);
    check("rst_note_denom", int'(note_denom), 0);
    check("rst_coin_valid", int'(coin_valid), 0);
    check("rst_coin_amt",   int'(coin_amt),   0);
    check("rst_done",       int'(done),       0);
    check("rst_busy",       int'(busy),       0);
    check("rst_fifo_full",  int'(fifo_full),  0);
    check("rst_overflow",   int'(overflow),   0);
    @(negedge clk);
    rstn = 1'b1;
    step();

    // Directed table, hopper always ready
    note_ready = 1'b1;
    for (int v = 0; v < 10; v++) begin
      clear_obs();
      push(tbl[v].amt);
      wait_done(1, (tbl[v].amt == 0) ? 15 : 3000);
      step(); step();
      check("tbl_done",      obs_done,      tbl[v].dones);
      check("tbl_notes",     obs_notes,     tbl[v].notes);
      check("tbl_sum",       obs_sum,       tbl[v].sum);
      check("tbl_first",     obs_first,     tbl[v].first);
      check("tbl_coin_amt",  obs_coin,      tbl[v].coin);
      check("tbl_coin_cnt",  obs_coin_cnt,  (tbl[v].coin != 0) ? 1 : 0);
      check("tbl_order",     obs_order_bad, 0);
      check("tbl_busy_idle", int'(busy),    0);
    end

    // Latency and stall: 60 with hopper stalled on the first note
    clear_obs();
    note_ready = 1'b0;
    push(60);
    check("lat_edge_n", int'(note_valid), 0);
    step();
    check("lat_edge_n1", int'(note_valid), 0);
    step();
    check("lat_edge_n2", int'(note_valid), 1);
    stall_bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!note_valid || note_denom != 7'd50) stall_bad++;
    end
    check("stall_hold", stall_bad, 0);
    check("stall_denom", int'(note_denom), 50);
    note_ready = 1'b1;
    wait_done(1, 50);
    check("stall_notes", obs_notes, 2);
    check("stall_sum",   obs_sum,   60);
    check("stall_done",  obs_done,  1);

    // Overflow: six back-to-back pushes with hopper stalled
    step();
    clear_obs();
    note_ready = 1'b0;
    chg_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chg_amount = AW'(5 + 5 * i);
      step();
    end
    chg_valid = 1'b0;
    chg_amount = '0;
    check("ovf_full",     int'(fifo_full),  1);
    check("ovf_flag",     int'(overflow),   1);
    check("ovf_busy",     int'(busy),       1);
    check("ovf_nv",       int'(note_valid), 1);
    note_ready = 1'b1;
    wait_done(5, 400);
    step(); step(); step();
    check("ovf_dones",    obs_done,        5);
    check("ovf_sum",      obs_sum,         5 + 10 + 15 + 20 + 25);
    check("ovf_sticky",   int'(overflow),  1);
    check("ovf_notfull",  int'(fifo_full), 0);
    check("ovf_idle",     int'(busy),      0);

    // Reset while a note is pending and two requests are queued
    clear_obs();
    note_ready = 1'b0;
    chg_valid = 1'b1;
    chg_amount = AW'(30); step();
    chg_amount = AW'(40); step();
    chg_amount = AW'(50); step();
    chg_valid = 1'b0;
    chg_amount = '0;
    step();
    check("mrst_pre_nv", int'(note_valid), 1);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("mrst_nv",    int'(note_valid), 0);
    check("mrst_denom", int'(note_denom), 0);
    check("mrst_busy",  int'(busy),       0);
    check("mrst_full",  int'(fifo_full),  0);
    check("mrst_ovf",   int'(overflow),   0);
    check("mrst_done",  int'(done),       0);
    @(negedge clk);
    rstn = 1'b1;
    clear_obs();
    note_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check("mrst_no_notes", obs_notes, 0);
    check("mrst_no_done",  obs_done,  0);
    check("mrst_idle",     int'(busy), 0);

    // Randomized phase against the reference model
    clear_obs();
    exp_q.delete();
    sb_en = 1'b1;
    rand_ready = 1'b1;
    pushed = 0;
    rand_sum = 0;
    for (int i = 0; i < 250; i++) begin
      n = $urandom_range(0, 3);
      for (int g = 0; g < n; g++) step();
      if (pushed - obs_done < DEPTH) begin
        int amt;
        amt = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 500);
        if (amt != 0) begin
          model_request(amt);
          pushed++;
          rand_sum += amt;
        end
        push(amt);
      end else begin
        step();
      end
    end
    n = 0;
    while (obs_done < pushed && n < 20000) begin
      step();
      n++;
    end
    step(); step();
    check("rand_dones",    obs_done,       pushed);
    check("rand_leftover", exp_q.size(),   0);
    check("rand_ovf",      int'(overflow), 0);
    check("rand_idle",     int'(busy),     0);
`ifdef CHANGE_STATS_EN
    check("stats_value",   int'(value_total), rand_sum);
    check("stats_coins",   int'(coins_total), obs_coin_cnt);
    check("stats_notes",   int'(notes_total), obs_notes);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
